instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the 64-bit ARM pipeline, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives a req/ack handshake to instruction memory.
- Buffers up to two fetched instructions and presents the oldest to IF/ID with its PC.
- Handles stalls from the hazard unit (`IF_ID_write` low) and branch redirects, including discarding a memory response that is already in flight.

## Interface
- `RESET_PC`, default 64'h0: first fetch address after reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high. Has priority over all other inputs.
- `IF_ID_write` in 1: IF/ID accepts the presented instruction at this edge. Low means stall.
- `br_taken` in 1: redirect request, single-cycle pulse.
- `br_target` in 64: redirect address. Bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: memory request.
- `imem_addr` out 64: request address. Held stable while `imem_req` is high.
- `imem_ack` in 1: read data valid. Asserted only in a cycle where `imem_req` is high; may arrive in the same cycle as the request (zero-wait).
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `instruction_out` out 32: head instruction, or NOP (32'hD503201F) when the buffer is empty.
- `pc_out` out 64: PC of the head instruction, 0 when the buffer is empty.
- `inst_valid` out 1: buffer non-empty.
- `if_flush` out 1: equals `br_taken` combinationally; drives the IF/ID flush input.

## Operation
- **Registers:** `fetch_pc` (next address to request), `req_addr`, state, 2-entry FIFO of {pc, inst}, `count` in 0..2.
- **States:**
  - F_IDLE: `imem_req`=0. Go to F_FETCH when `count_next` < 2.
  - F_FETCH: `imem_req`=1, `imem_addr`=`req_addr`. On `imem_ack`:
    - push {`req_addr`, `imem_rdata`};
    - `fetch_pc` += 4;
    - if `count_next` < 2, stay in F_FETCH with `req_addr` = new `fetch_pc`; otherwise go to F_IDLE.
  - F_DROP: `imem_req`=1 on the old `req_addr`. On `imem_ack`, discard the data, load `req_addr` from `fetch_pc`, and go to F_FETCH.
- **Outstanding requests:** at most one. A request is raised only when `count` < 2, so a push never overflows the FIFO.
- **Pop:** at an edge with `inst_valid` & `IF_ID_write` & !`br_taken`. Push and pop in the same cycle leaves `count` unchanged.
- **Redirect (`br_taken`)**, evaluated after pop and push:
  - FIFO cleared (`count` 0).
  - `fetch_pc` = {`br_target`[63:2], 2'b00}.
  - Any ack arriving in the same cycle is discarded.
  - Next state:
    - F_FETCH without ack goes to F_DROP.
    - F_FETCH with ack, and F_IDLE, go to F_FETCH with `req_addr` = target.
    - F_DROP stays in F_DROP, with `fetch_pc` updated to the target.
- **PC arithmetic:** 64-bit, wraps modulo 2^64.
- **Reset mid-operation:** any outstanding request is abandoned. The memory side shares `rst` and aborts too.

## Timing
- **Reset values:** state F_IDLE, `fetch_pc`=`req_addr`=`RESET_PC`, `count` 0, `imem_req` 0, `inst_valid` 0, `instruction_out` NOP, `pc_out` 0, `if_flush` 0.
- **First fetch:** cycle 0 is the first cycle with `rst` low. `imem_req` is high in cycle 1. With a zero-wait ack, `inst_valid`=1 in cycle 2.
- **Throughput:** 1 instruction/cycle with zero-wait memory and no stalls.
- **Output path:** FIFO head outputs are driven combinationally from FIFO registers.
- **Flush path:** `if_flush` is a combinational path from `br_taken`.

## Configuration
- `FETCH_PERF_CNT_EN` defined adds two 32-bit wrapping outputs, both reset to 0:
  - `stall_cycles`: counts cycles with `inst_valid` & !`IF_ID_write`.
  - `redirect_count`: counts cycles with `br_taken`.
- `FETCH_PERF_CNT_EN` undefined: these ports and their logic are absent.

## Structure
- **Package `structures`:**
  - `NOP_INST` = 32'hD503201F;
  - `fetch_state_t` enum {F_IDLE, F_FETCH, F_DROP};
  - `fetch_entry_t` struct {logic [63:0] pc; logic [31:0] inst}.
- **Sub-module `fetch_buffer`:** 2-entry FIFO with push, pop, clear, `count`, and head outputs.

## Test plan
- Reset, zero-wait memory, `IF_ID_write`=1 throughout -> `imem_addr` 0 in cycle 1; `pc_out` 0, 4, 8, 12 in cycles 2-5; `inst_valid` continuously 1.
- `IF_ID_write`=0 for cycles 4-8 -> `count` reaches 2, `imem_req` low, `pc_out` held; on release, `pc_out` advances by 4 per cycle with no gap or duplicate.
- 3-cycle memory latency, `br_taken` with target 0x100 while the 0x10 request is pending -> F_DROP; the 0x10 data never appears; next `imem_addr` is 0x100; first valid `pc_out` is 0x100.
- `br_taken` (target 0x200) in the same cycle as ack and pop -> `if_flush`=1 that cycle; `inst_valid`=0 next cycle; next request 0x200.
- `br_target` 0x103 -> `imem_addr` 0x100.
- `FETCH_PERF_CNT_EN` defined, 5 stall cycles and 2 redirects -> `stall_cycles`=5, `redirect_count`=2; `rst` clears both.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package structures;

  localparam logic [31:0] NOP_INST  = 32'hD503201F;
  localparam logic [63:0] PC_STEP   = 64'd4;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_FETCH = 2'd1,
    F_DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits carry no meaning.
  function automatic logic [63:0] align_word(input logic [63:0] addr);
    return addr & 64'hFFFF_FFFF_FFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry FIFO of {pc, inst} between instruction memory and IF/ID.
module fetch_buffer
  import structures::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  fetch_entry_t entry_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;
  logic         pop_ok_s;
  logic         push_ok_s;

  assign pop_ok_s  = pop && (count_r != 2'd0);
  assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);

  // Storage, pointers and occupancy; clear only drops occupancy, stale words are never read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      entry_r[0] <= '0;
      entry_r[1] <= '0;
    end else if (clear) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_ok_s) begin
        entry_r[wr_ptr_r] <= push_entry;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
    end
  end

  assign count      = count_r;
  assign head_valid = (count_r != 2'd0);
  assign head_entry = entry_r[rd_ptr_r];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, runs the imem req/ack handshake and feeds IF/ID.
// Optional FETCH_PERF_CNT_EN adds stall_cycles / redirect_count counters.
module instruction_fetch
  import structures::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_ID_write,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [63:0] pc_out,
  output logic        inst_valid,
  output logic        if_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);

  fetch_state_t state_r;
  fetch_state_t state_next_s;
  logic [63:0]  fetch_pc_r;
  logic [63:0]  fetch_pc_next_s;
  logic [63:0]  req_addr_r;
  logic [63:0]  req_addr_next_s;
  logic [63:0]  target_s;
  logic [1:0]   count_s;
  logic [1:0]   count_next_s;
  logic         push_s;
  logic         pop_s;
  logic         head_valid_s;
  fetch_entry_t head_entry_s;
  fetch_entry_t push_entry_s;

  assign target_s     = align_word(br_target);
  assign push_s       = (state_r == F_FETCH) && imem_ack && !br_taken;
  assign pop_s        = head_valid_s && IF_ID_write && !br_taken;
  assign push_entry_s = '{pc: req_addr_r, inst: imem_rdata};

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .clear      (br_taken),
    .push_entry (push_entry_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head_entry (head_entry_s)
  );

  // Occupancy after this edge; a redirect empties the buffer
  always_comb begin
    count_next_s = 2'd0;
    if (br_taken) begin
      count_next_s = 2'd0;
    end else begin
      count_next_s = count_s + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // Next-state and address logic; the redirect overlay is applied last so it wins
  always_comb begin
    state_next_s    = state_r;
    fetch_pc_next_s = fetch_pc_r;
    req_addr_next_s = req_addr_r;
    case (state_r)
      F_IDLE: begin
        if (count_next_s < 2'd2) begin
          state_next_s    = F_FETCH;
          req_addr_next_s = fetch_pc_r;
        end else begin
          state_next_s = F_IDLE;
        end
      end
      F_FETCH: begin
        if (imem_ack) begin
          fetch_pc_next_s = fetch_pc_r + PC_STEP;
          req_addr_next_s = fetch_pc_r + PC_STEP;
          if (count_next_s < 2'd2) begin
            state_next_s = F_FETCH;
          end else begin
            state_next_s = F_IDLE;
          end
        end else begin
          state_next_s = F_FETCH;
        end
      end
      F_DROP: begin
        if (imem_ack) begin
          state_next_s    = F_FETCH;
          req_addr_next_s = fetch_pc_r;
        end else begin
          state_next_s = F_DROP;
        end
      end
      default: begin
        state_next_s = F_IDLE;
      end
    endcase

    // A request without its ack cannot be withdrawn, so its response is drained in F_DROP
    if (br_taken) begin
      fetch_pc_next_s = target_s;
      case (state_r)
        F_FETCH: begin
          if (imem_ack) begin
            state_next_s    = F_FETCH;
            req_addr_next_s = target_s;
          end else begin
            state_next_s    = F_DROP;
            req_addr_next_s = req_addr_r;
          end
        end
        F_IDLE: begin
          state_next_s    = F_FETCH;
          req_addr_next_s = target_s;
        end
        F_DROP: begin
          state_next_s    = F_DROP;
          req_addr_next_s = req_addr_r;
        end
        default: begin
          state_next_s = F_IDLE;
        end
      endcase
    end else begin
      fetch_pc_next_s = fetch_pc_next_s;
    end
  end

  // State, fetch PC and request address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= F_IDLE;
      fetch_pc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
    end else begin
      state_r    <= state_next_s;
      fetch_pc_r <= fetch_pc_next_s;
      req_addr_r <= req_addr_next_s;
    end
  end

  assign imem_req        = (state_r != F_IDLE);
  assign imem_addr       = req_addr_r;
  assign inst_valid      = head_valid_s;
  assign instruction_out = head_valid_s ? head_entry_s.inst : NOP_INST;
  assign pc_out          = head_valid_s ? head_entry_s.pc : 64'h0;
  assign if_flush        = br_taken;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles_r;
  logic [31:0] redirect_count_r;

  // Free-running wrapping event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_r   <= 32'd0;
      redirect_count_r <= 32'd0;
    end else begin
      if (head_valid_s && !IF_ID_write) begin
        stall_cycles_r <= stall_cycles_r + 32'd1;
      end
      if (br_taken) begin
        redirect_count_r <= redirect_count_r + 32'd1;
      end
    end
  end

  assign stall_cycles   = stall_cycles_r;
  assign redirect_count = redirect_count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed cycle table, hand sequences and a random
// run checked against an in-order instruction-stream reference.
module tb_instruction_fetch;
  import structures::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_ID_write;
  logic        br_taken;
  logic [63:0] br_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [63:0] pc_out;
  logic        inst_valid;
  logic        if_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;
`endif

  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_write     (IF_ID_write),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .inst_valid      (inst_valid),
    .if_flush        (if_flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .redirect_count  (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit          wr;
    bit          br;
    logic [63:0] tgt;
    bit          req;
    logic [63:0] addr;
    bit          valid;
    logic [63:0] pc;
  } vec_t;

  vec_t        tbl [18];
  int          n_vec = 0;
  int          n_err = 0;
  int          lat = 0;
  int          wcnt = 0;
  bit          lat_rand = 1'b0;
  logic [63:0] exp_pc;
  bit          pend_r;
  logic [63:0] pend_addr;
  int          accepts;
  bit          found;
  bit          got;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the negedge, answer memory, check the stream rules.
  task automatic drive(input bit wr, input bit br, input logic [63:0] tgt);
    IF_ID_write = wr;
    br_taken    = br;
    br_target   = tgt;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    if (imem_req) begin
      if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        wcnt++;
      end
    end
    #1;
    check64("if_flush", if_flush, br);
    if (inst_valid) begin
      check64("inst_word", instruction_out, mem_word(pc_out));
      if (wr && !br) begin
        check64("pop_pc", pc_out, exp_pc);
        exp_pc = exp_pc + 64'd4;
        accepts++;
      end
    end else begin
      check64("empty_inst", instruction_out, NOP_INST);
      check64("empty_pc", pc_out, 64'h0);
    end
    if (pend_r && imem_req) check64("addr_hold", imem_addr, pend_addr);
    if (br) exp_pc = tgt & 64'hFFFF_FFFF_FFFF_FFFC;
  endtask

  task automatic advance();
    pend_r    = imem_req && !imem_ack;
    pend_addr = imem_addr;
    if (imem_ack) begin
      wcnt = 0;
      if (lat_rand) lat = $urandom_range(0, 3);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; IF_ID_write = 1'b1; br_taken = 1'b0; br_target = 64'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check64("rst_req", imem_req, 1'b0);
    check64("rst_valid", inst_valid, 1'b0);
    check64("rst_inst", instruction_out, NOP_INST);
    check64("rst_pc", pc_out, 64'h0);
    check64("rst_flush", if_flush, 1'b0);
    check64("rst_addr", imem_addr, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check64("rst_stall_cnt", stall_cycles, 32'd0);
    check64("rst_redir_cnt", redirect_count, 32'd0);
`endif
    rst = 1'b0; exp_pc = 64'h0; wcnt = 0; pend_r = 1'b0; accepts = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    // Zero-wait memory: cycle-exact expectations from reset release (row i = cycle i)
    //        wr    br    tgt         req   addr        valid pc
    tbl[0]  = {1'b1, 1'b0, 64'h0,     1'b0, 64'h0,      1'b0, 64'h0};
    tbl[1]  = {1'b1, 1'b0, 64'h0,     1'b1, 64'h0,      1'b0, 64'h0};
    tbl[2]  = {1'b1, 1'b0, 64'h0,     1'b1, 64'h4,      1'b1, 64'h0};
    tbl[3]  = {1'b1, 1'b0, 64'h0,     1'b1, 64'h8,      1'b1, 64'h4};
    tbl[4]  = {1'b0, 1'b0, 64'h0,     1'b1, 64'hC,      1'b1, 64'h8};
    tbl[5]  = {1'b0, 1'b0, 64'h0,     1'b0, 64'h0,      1'b1, 64'h8};
    tbl[6]  = {1'b0, 1'b0, 64'h0,     1'b0, 64'h0,      1'b1, 64'h8};
    tbl[7]  = {1'b0, 1'b0, 64'h0,     1'b0, 64'h0,      1'b1, 64'h8};
    tbl[8]  = {1'b0, 1'b0, 64'h0,     1'b0, 64'h0,      1'b1, 64'h8};
    tbl[9]  = {1'b1, 1'b0, 64'h0,     1'b0, 64'h0,      1'b1, 64'h8};
    tbl[10] = {1'b1, 1'b0, 64'h0,     1'b1, 64'h10,     1'b1, 64'hC};
    tbl[11] = {1'b1, 1'b0, 64'h0,     1'b1, 64'h14,     1'b1, 64'h10};
    tbl[12] = {1'b1, 1'b1, 64'h200,   1'b1, 64'h18,     1'b1, 64'h14};
    tbl[13] = {1'b1, 1'b0, 64'h0,     1'b1, 64'h200,    1'b0, 64'h0};
    tbl[14] = {1'b1, 1'b0, 64'h0,     1'b1, 64'h204,    1'b1, 64'h200};
    tbl[15] = {1'b1, 1'b1, 64'h103,   1'b1, 64'h208,    1'b1, 64'h204};
    tbl[16] = {1'b1, 1'b0, 64'h0,     1'b1, 64'h100,    1'b0, 64'h0};
    tbl[17] = {1'b1, 1'b0, 64'h0,     1'b1, 64'h104,    1'b1, 64'h100};

    @(negedge clk);
    do_reset();
    lat = 0; lat_rand = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].wr, tbl[i].br, tbl[i].tgt);
      check64($sformatf("tbl%0d_req", i), imem_req, tbl[i].req);
      if (tbl[i].req) check64($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      check64($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].valid);
      check64($sformatf("tbl%0d_pc", i), pc_out, tbl[i].pc);
      advance();
    end

    // Three-cycle latency: redirect while the 0x10 request is still outstanding
    do_reset();
    lat = 3; lat_rand = 1'b0; found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (imem_req && imem_addr == 64'h10 && wcnt < lat) begin
        drive(1'b1, 1'b1, 64'h100);
        found = 1'b1;
      end else begin
        drive(1'b1, 1'b0, 64'h0);
      end
      advance();
    end
    check64("drop_hit", found, 1'b1);
    check64("drop_flushed", inst_valid, 1'b0);
    check64("drop_req", imem_req, 1'b1);
    check64("drop_addr", imem_addr, 64'h10);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (imem_req && imem_addr != 64'h10) begin
        check64("redirect_addr", imem_addr, 64'h100);
        got = 1'b1;
      end else begin
        drive(1'b1, 1'b0, 64'h0);
        advance();
      end
    end
    check64("redirect_seen", got, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (inst_valid) begin
        check64("first_pc", pc_out, 64'h100);
        got = 1'b1;
      end else begin
        drive(1'b1, 1'b0, 64'h0);
        advance();
      end
    end
    check64("first_valid_seen", got, 1'b1);

    // Randomized stalls, redirects (including near the wrap point) and latencies
    do_reset();
    lat_rand = 1'b1; lat = $urandom_range(0, 3);
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] tgt;
      case ($urandom_range(0, 2))
        0:       tgt = {$urandom(), $urandom()};
        1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
        default: tgt = 64'($urandom_range(0, 4095));
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, tgt);
      advance();
    end
    check64("progress", accepts >= 300, 1'b1);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    lat = 0; lat_rand = 1'b0;
    for (int i = 0; i < 10 && !inst_valid; i++) begin
      drive(1'b1, 1'b0, 64'h0);
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 64'h0);
      advance();
    end
    drive(1'b1, 1'b1, 64'h300); advance();
    drive(1'b1, 1'b0, 64'h0);   advance();
    drive(1'b1, 1'b1, 64'h400); advance();
    check64("stall_cycles", stall_cycles, 32'd5);
    check64("redirect_count", redirect_count, 32'd2);
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
